// File: rtl/bus_rr_scheduler_if.sv
// bus_rr_scheduler_if: FIFO-side request/data and bus-side push signals of the round-robin scheduler.
interface bus_rr_scheduler_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    localparam int gw = $clog2(drvrs);
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [drvrs*pckg_sz-1:0] D_push;
    logic [gw-1:0]            grant_id;
    logic                     busy;
    logic                     drop;
    modport master (input pndng, D_pop, output pop, push, D_push, grant_id, busy, drop);
    modport slave  (output pndng, D_pop, input pop, push, D_push, grant_id, busy, drop);
endinterface

// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler: round-robin IDLE/POP/PUSH scheduler from per-device FIFOs onto the broadcast bus.
// Define BUS_BCAST_EN to deliver the broadcast ID to every device except the source.
module bus_rr_scheduler #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input logic clk,
    input logic reset,
    bus_rr_scheduler_if.master bus
);
    localparam int gw = $clog2(drvrs);
    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
    state_t state, state_n;
    logic [gw-1:0]      rr_ptr, rr_n, grant, grant_n, winner;
    logic [pckg_sz-1:0] pkt, pkt_n, head;
    logic [drvrs-1:0]   pop, pop_n, push, push_n, hit, src, dec;
    logic               drop, drop_n, found;
    logic [7:0]         dest;

    assign head = bus.D_pop[grant*pckg_sz +: pckg_sz];
    assign dest = head[pckg_sz-1 -: 8];

    // First pending source at or after rr_ptr, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < drvrs; i++) begin
            if (!found && bus.pndng[(int'(rr_ptr) + i) % drvrs]) begin
                winner = gw'((int'(rr_ptr) + i) % drvrs);
                found  = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < drvrs; i++) begin : g_dec
        assign hit[i] = dest == 8'(i);
        assign src[i] = grant == gw'(i);
    end

`ifdef BUS_BCAST_EN
    assign dec = dest == broadcast ? ~src : hit;
`else
    assign dec = dest == broadcast ? '0 : hit;
`endif

    // Outputs are computed one state ahead so pop/push/drop come straight from flops.
    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        grant_n = grant;
        pkt_n   = pkt;
        pop_n   = '0;
        push_n  = '0;
        drop_n  = 1'b0;
        case (state)
            IDLE: if (|bus.pndng) begin
                state_n = POP;
                grant_n = winner;
                rr_n    = winner == gw'(drvrs - 1) ? '0 : winner + 1'b1;
                pop_n   = drvrs'(1) << winner;
            end
            POP: begin
                state_n = PUSH;
                pkt_n   = head;
                push_n  = dec;
                drop_n  = ~|dec;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            pkt    <= '0;
            pop    <= '0;
            push   <= '0;
            drop   <= 1'b0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_n;
            grant  <= grant_n;
            pkt    <= pkt_n;
            pop    <= pop_n;
            push   <= push_n;
            drop   <= drop_n;
        end
    end

    assign bus.pop      = pop;
    assign bus.push     = push;
    assign bus.drop     = drop;
    assign bus.grant_id = grant;
    assign bus.busy     = state != IDLE;
    assign bus.D_push   = {drvrs{pkt}};
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// tb_bus_rr_scheduler: directed and random packets against an arithmetic round-robin model.
module tb_bus_rr_scheduler;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] pk [4];
    int compared = 0, mism = 0, cyc = 0, rr = 0, last_g = 0, last_pop = 0, prev_pop = 0;

    bus_rr_scheduler_if #(.drvrs(4), .pckg_sz(16)) bif ();
    bus_rr_scheduler #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    assign bif.D_pop = {pk[3], pk[2], pk[1], pk[0]};
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pop"}, 64'(bif.pop), 0);
        chk({tag, "_push"}, 64'(bif.push), 0);
        chk({tag, "_dpush"}, bif.D_push, 0);
        chk({tag, "_grant"}, 64'(bif.grant_id), 0);
        chk({tag, "_busy"}, 64'(bif.busy), 0);
        chk({tag, "_drop"}, 64'(bif.drop), 0);
    endtask

    task automatic send(input logic [3:0] m);
        int g;
        logic [7:0] d;
        logic [3:0] ep;
        g = -1;
        bif.pndng = m;
        for (int i = 0; i < 4; i++) if (g < 0 && m[(rr + i) % 4]) g = (rr + i) % 4;
        @(posedge clk); #1;
        if (g < 0) begin
            chk("idle_pop", 64'(bif.pop), 0);
            chk("idle_busy", 64'(bif.busy), 0);
            return;
        end
        last_g = g;
        last_pop = cyc;
        chk("pop", 64'(bif.pop), 64'(1 << g));
        chk("grant", 64'(bif.grant_id), 64'(g));
        chk("busy_pop", 64'(bif.busy), 1);
        chk("push_in_pop", 64'(bif.push), 0);
        bif.pndng = 4'($urandom);
        @(posedge clk); #1;
        d = pk[g][15:8];
        ep = 4'b0000;
        if (d < 4) ep = 4'(1 << d);
`ifdef BUS_BCAST_EN
        else if (d == 8'hFF) ep = ~4'(1 << g);
`endif
        chk("push", 64'(bif.push), 64'(ep));
        chk("drop", 64'(bif.drop), 64'(ep == 0));
        chk("dpush", bif.D_push, {4{pk[g]}});
        chk("pop_in_push", 64'(bif.pop), 0);
        chk("busy_push", 64'(bif.busy), 1);
        bif.pndng = 4'b0000;
        @(posedge clk); #1;
        chk("busy_idle", 64'(bif.busy), 0);
        chk("push_idle", 64'(bif.push), 0);
        chk("drop_idle", 64'(bif.drop), 0);
        rr = (g + 1) % 4;
    endtask

    initial begin
        reset = 1'b1;
        bif.pndng = 4'b0000;
        for (int i = 0; i < 4; i++) pk[i] = 16'h0000;
        #1 chk_zero("rst");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        pk[2] = 16'h0155;
        send(4'b0100);
        pk[2] = 16'h0000;
        pk[3] = 16'h07AA;
        send(4'b1000);
        chk("inval_src", 64'(last_g), 3);
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 4; i++) pk[i] = 16'h0012 + 16'(i);
            prev_pop = last_pop;
            send(4'b1111);
            chk("fair_order", 64'(last_g), 64'(j % 4));
            if (j > 0) chk("pop_gap", 64'(last_pop - prev_pop), 3);
        end
        pk[1] = 16'hFFAA;
        send(4'b0010);
        pk[2] = 16'h02AB;
        send(4'b0100);
        chk("self_src", 64'(last_g), 2);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 5);
                pk[i] = {r < 4 ? 8'(r) : (r == 4 ? 8'hFF : 8'($urandom)), 8'($urandom)};
            end
            send(4'($urandom_range(0, 15)));
        end
        pk[0] = 16'h0311;
        bif.pndng = 4'b0001;
        @(posedge clk); #1;
        chk("rst_mid_pop", 64'(bif.pop), 1);
        #2 reset = 1'b1;
        #1 chk_zero("rst_mid");
        @(posedge clk); #1;
        chk("rst_hold_push", 64'(bif.push), 0);
        bif.pndng = 4'b0000;
        @(negedge clk) reset = 1'b0;
        rr = 0;
        @(posedge clk); #1;
        chk("rst_after_push", 64'(bif.push), 0);
        chk("rst_after_busy", 64'(bif.busy), 0);
        pk[0] = 16'h0111;
        send(4'b0001);
        chk("rst_regrant", 64'(last_g), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler for the shared broadcast bus. It sits between the `drvrs` per-device input FIFOs and the bus output ports. When a FIFO reports pending data, the scheduler grants it, pops one packet, decodes the destination ID from the packet header and pushes the packet to the addressed device or devices. Only one packet is in flight at a time, and grants rotate fairly across sources.

## Interface
- `drvrs`, default 4: number of devices on the bus; minimum 2.
- `pckg_sz`, default 16: packet width in bits; minimum 9.
- `broadcast`, default 8'hFF: destination ID that means "all devices".
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `pndng` in `drvrs`: bit i high means FIFO i holds at least one packet.
- `D_pop` in `drvrs*pckg_sz`: head-of-FIFO data; slice i is `[i*pckg_sz +: pckg_sz]`.
- `pop` out `drvrs`: one-hot, one-cycle pop strobe to the granted FIFO.
- `push` out `drvrs`: push strobe per destination device.
- `D_push` out `drvrs*pckg_sz`: every slice carries the latched packet.
- `grant_id` out `$clog2(drvrs)`: index of the source currently granted.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `drop` out 1: one-cycle pulse when a packet is discarded.

## Operation
- Destination ID is `pkt[pckg_sz-1 -: 8]`. The remaining bits are payload and pass through untouched.
- Round-robin pointer `rr_ptr` (width `$clog2(drvrs)`) marks the highest-priority source.
  - Winner is the first set `pndng` bit scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo `drvrs`.
  - After each grant, `rr_ptr` becomes `(grant+1) mod drvrs`, including when the packet is dropped.
- FSM states are IDLE, POP and PUSH.
  - IDLE: if `pndng != 0`, latch the winner into `grant_id` and go to POP. Otherwise stay.
  - POP: assert `pop[grant_id]`, capture `pkt <= D_pop[grant_id]` and go to PUSH.
  - PUSH: decode the destination and drive outputs as below, then go to IDLE.
    - Destination less than `drvrs`: `push[dest]=1`. A destination equal to the source is delivered normally.
    - Destination equal to `broadcast`: see Configuration.
    - Any other destination: `push=0` and `drop=1`.
- `D_push` holds `pkt` from PUSH onward and keeps that value until the next capture.
- `pndng` is sampled only in IDLE. Changes on `pndng` during POP or PUSH have no effect.
- Reset mid-operation returns the FSM to IDLE immediately. Any packet already popped but not yet pushed is lost, and no `push` is emitted for it.

## Timing
- Reset values:
  - `pop`, `push`, `D_push`, `grant_id`, `busy`, `drop` all 0.
  - `rr_ptr` 0 and `pkt` 0.
- Latency, with `pndng` first sampled high at edge k (FSM in IDLE):
  - `pop` is high during cycle k+1.
  - `push` or `drop` is high during cycle k+2.
- Throughput is one packet per 3 cycles under continuous requests.
- `pop` and `push` are registered outputs; neither is ever high for more than one consecutive cycle.
- `busy` is high in POP and PUSH.
- Every granted packet produces exactly one PUSH-state cycle, with either a non-zero `push` or `drop=1`, never both.
- `D_pop[grant_id]` must be valid in the POP cycle; FIFO head data is valid while `pndng` is high.

## Configuration
- `BUS_BCAST_EN` defined: destination `broadcast` asserts `push` to every device except the source, i.e. `push = ~(1<<grant_id)`.
- `BUS_BCAST_EN` undefined: destination `broadcast` is handled as an out-of-range ID: `push=0` and `drop=1`. The broadcast decode logic is not compiled.

## Test plan
All scenarios use `drvrs=4`, `pckg_sz=16`.
- Single request: `pndng=4'b0100`, `D_pop[2]=16'h0155`.
  - Required: `pop=4'b0100` in cycle k+1.
  - Required: `push=4'b0010` and `D_push` slices equal 16'h0155 in cycle k+2.
  - Required afterwards: `rr_ptr=3`.
- Fairness: hold `pndng=4'b1111` with every packet addressed to device 0.
  - Required: grant order 0,1,2,3,0.
  - Required: `pop` pulses spaced exactly 3 cycles apart.
- Broadcast: source 1 sends 16'hFFAA.
  - With `BUS_BCAST_EN` defined: `push=4'b1101` and `drop=0`.
  - Without `BUS_BCAST_EN`: `push=0` and `drop=1`.
- Invalid destination: source 3 sends 16'h07AA.
  - Required: `drop=1` for one cycle and `push=0`.
  - Required: the next grant starts its scan at source 0.
- Reset mid-op: assert `reset` during the POP cycle.
  - Required: all outputs 0 asynchronously and no `push` for that packet.
  - Required after release with `pndng=4'b0001`: grant 0 with normal latency.
- Self-send: source 2 sends 16'h02AB.
  - Required: `push=4'b0100` and `drop=0`.
